vend_controller_n: RTL and testbench

VEND_CONTROLLER_N -- requirements
Module: vend_controller_n

---
 rtl/vend_pkg.sv | 11 +
 rtl/vend_controller_n_if.sv | 42 ++++
 rtl/vend_credit_acc.sv | 41 ++++
 rtl/vend_controller_n.sv | 186 ++++++++++++++++++
 tb/tb_vend_controller_n.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM state encoding.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } vend_state_t;

endpackage

// File: rtl/vend_controller_n_if.sv
// User/config/dispenser/change-unit signals of the vending controller.
// The controller takes the slave view; the surrounding system takes the master view.
interface vend_controller_n_if #(
   parameter int NUM_ITEMS = 8,
   parameter int CREDIT_W  = 8
);
   localparam int IDX_W = $clog2(NUM_ITEMS);

   logic                cfg_mode;
   logic                cfg_wr;
   logic [IDX_W-1:0]    cfg_idx;
   logic [CREDIT_W-1:0] cfg_price;
   logic                sel_valid;
   logic [IDX_W-1:0]    sel_item;
   logic                coin_valid;
   logic [CREDIT_W-1:0] coin_value;
   logic                cancel;
   logic                dispense_ready;
   logic                change_ready;
   logic                dispense_enable;
   logic [IDX_W-1:0]    dispense_item;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_value;
   logic                coin_reject;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   modport slave (
      input  cfg_mode, cfg_wr, cfg_idx, cfg_price, sel_valid, sel_item,
             coin_valid, coin_value, cancel, dispense_ready, change_ready,
      output dispense_enable, dispense_item, change_valid, change_value,
             coin_reject, credit, busy
   );

   modport master (
      output cfg_mode, cfg_wr, cfg_idx, cfg_price, sel_valid, sel_item,
             coin_valid, coin_value, cancel, dispense_ready, change_ready,
      input  dispense_enable, dispense_item, change_valid, change_value,
             coin_reject, credit, busy
   );

endinterface

// File: rtl/vend_credit_acc.sv
// Credit register with saturating coin add, clear, price subtract and
// a combinational "credit after this coin >= price" compare.
module vend_credit_acc #(
   parameter int CREDIT_W = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                clear,
   input  logic                add_en,
   input  logic [CREDIT_W-1:0] add_value,
   input  logic                sub_en,
   input  logic [CREDIT_W-1:0] price,
   output logic [CREDIT_W-1:0] credit,
   output logic [CREDIT_W-1:0] sum,
   output logic                sum_ge_price,
   output logic                saturated
);

   logic [CREDIT_W-1:0] credit_reg;
   logic [CREDIT_W:0]   raw_sum;

   // One extra bit catches the carry that signals saturation.
   assign raw_sum      = {1'b0, credit_reg} + {1'b0, (add_en ? add_value : {CREDIT_W{1'b0}})};
   assign saturated    = raw_sum[CREDIT_W];
   assign sum          = raw_sum[CREDIT_W] ? {CREDIT_W{1'b1}} : raw_sum[CREDIT_W-1:0];
   assign sum_ge_price = (sum >= price);
   assign credit       = credit_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         credit_reg <= '0;
      end else if (clear) begin
         credit_reg <= '0;
      end else if (sub_en) begin
         credit_reg <= credit_reg - price;
      end else if (add_en) begin
         credit_reg <= sum;
      end
   end

endmodule

// File: rtl/vend_controller_n.sv
// Vending controller: item select, coin collection, dispense and refund handshakes.
// Optional idle-payment auto-refund is compiled in with `define VEND_TIMEOUT_EN.
module vend_controller_n
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS   = 8,
   parameter int CREDIT_W    = 8,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                 clk,
   input  logic                 rstn,
   vend_controller_n_if.slave   bus
);

   localparam int IDX_W = $clog2(NUM_ITEMS);

   vend_state_t         state_reg, state_next;
   logic [IDX_W-1:0]    item_reg, item_next;
   logic [CREDIT_W-1:0] price_reg, price_next;
   logic [CREDIT_W-1:0] change_reg, change_next;
   logic                reject_next;
   logic                dispense_enable_reg, dispense_item_unused_bit;
   logic [IDX_W-1:0]    dispense_item_reg;
   logic                change_valid_reg;
   logic                coin_reject_reg;
   logic                busy_reg;

   logic [CREDIT_W-1:0] price_tab_reg [NUM_ITEMS];
   logic [NUM_ITEMS-1:0] price_we;
   logic                cfg_we;

   logic                acc_clear, acc_add, acc_sub;
   logic [CREDIT_W-1:0] credit, acc_sum;
   logic                acc_ge, acc_sat;
   logic                timeout;

   assign dispense_item_unused_bit = 1'b0;

   // Price writes are only honoured while idle in configuration mode.
   assign cfg_we = bus.cfg_mode && bus.cfg_wr && (state_reg == ST_IDLE);

   for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price_we
      assign price_we[gi] = cfg_we && (bus.cfg_idx == IDX_W'(gi));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_ITEMS; i++) price_tab_reg[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            if (price_we[i]) price_tab_reg[i] <= bus.cfg_price;
         end
      end
   end

   vend_credit_acc #(.CREDIT_W(CREDIT_W)) u_acc (
      .clk          (clk),
      .rstn         (rstn),
      .clear        (acc_clear),
      .add_en       (acc_add),
      .add_value    (bus.coin_value),
      .sub_en       (acc_sub),
      .price        (price_reg),
      .credit       (credit),
      .sum          (acc_sum),
      .sum_ge_price (acc_ge),
      .saturated    (acc_sat)
   );

`ifdef VEND_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt_reg;

   // Counter idles at zero outside COLLECT, so COLLECT entry always starts fresh.
   assign timeout = (state_reg == ST_COLLECT) && !bus.coin_valid &&
                    (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tmo_cnt_reg <= '0;
      end else if ((state_reg != ST_COLLECT) || bus.coin_valid || timeout) begin
         tmo_cnt_reg <= '0;
      end else begin
         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
   end
`else
   localparam int timeout_cyc_unused = TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      item_next   = item_reg;
      price_next  = price_reg;
      change_next = change_reg;
      reject_next = 1'b0;
      acc_clear   = 1'b0;
      acc_add     = 1'b0;
      acc_sub     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            reject_next = bus.coin_valid;
            if (bus.sel_valid && !bus.cfg_mode) begin
               state_next = ST_COLLECT;
               item_next  = bus.sel_item;
               price_next = price_tab_reg[bus.sel_item];
            end
         end
         ST_COLLECT: begin
            acc_add     = bus.coin_valid;
            reject_next = acc_sat;
            // Abort paths beat a same-cycle price match; refund includes this cycle's coin.
            if (bus.cancel || bus.cfg_mode || timeout) begin
               if (acc_sum == '0) begin
                  state_next = ST_IDLE;
                  acc_clear  = 1'b1;
               end else begin
                  state_next  = ST_CHANGE;
                  change_next = acc_sum;
               end
            end else if (acc_ge) begin
               state_next = ST_DISPENSE;
            end
         end
         ST_DISPENSE: begin
            reject_next = bus.coin_valid;
            if (bus.dispense_ready) begin
               if (credit > price_reg) begin
                  state_next  = ST_CHANGE;
                  change_next = credit - price_reg;
                  acc_sub     = 1'b1;
               end else begin
                  state_next = ST_IDLE;
                  acc_clear  = 1'b1;
               end
            end
         end
         ST_CHANGE: begin
            reject_next = bus.coin_valid;
            if (bus.change_ready) begin
               state_next  = ST_IDLE;
               change_next = '0;
               acc_clear   = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            acc_clear  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg           <= ST_IDLE;
         item_reg            <= '0;
         price_reg           <= '0;
         change_reg          <= '0;
         dispense_enable_reg <= 1'b0;
         dispense_item_reg   <= '0;
         change_valid_reg    <= 1'b0;
         coin_reject_reg     <= 1'b0;
         busy_reg            <= 1'b0;
      end else begin
         state_reg           <= state_next;
         item_reg            <= item_next;
         price_reg           <= price_next;
         change_reg          <= change_next;
         dispense_enable_reg <= (state_next == ST_DISPENSE);
         dispense_item_reg   <= (state_next == ST_DISPENSE) ? item_next : {IDX_W{dispense_item_unused_bit}};
         change_valid_reg    <= (state_next == ST_CHANGE);
         coin_reject_reg     <= reject_next;
         busy_reg            <= (state_next != ST_IDLE);
      end
   end

   assign bus.dispense_enable = dispense_enable_reg;
   assign bus.dispense_item   = dispense_item_reg;
   assign bus.change_valid    = change_valid_reg;
   assign bus.change_value    = change_reg;
   assign bus.coin_reject     = coin_reject_reg;
   assign bus.credit          = credit;
   assign bus.busy            = busy_reg;

endmodule

// File: tb/tb_vend_controller_n.sv
// Scoreboard bench for vend_controller_n: directed scenarios then randomized traffic,
// each cycle's expected outputs come from a transaction-level model of the vending rules.
module tb_vend_controller_n;

   localparam int NI  = 8;
   localparam int CW  = 8;
   localparam int TMO = 16;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   vend_controller_n_if #(.NUM_ITEMS(NI), .CREDIT_W(CW)) bus ();

   vend_controller_n #(.NUM_ITEMS(NI), .CREDIT_W(CW), .TIMEOUT_CYC(TMO)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      bit de; int di; bit cv; int cval; bit rej; int cr; bit busy;
   } exp_t;

   exp_t sb_q[$];
   int vectors = 0;
   int miscompares = 0;

   // Stimulus for the next cycle.
   bit i_rn, i_cm, i_cw, i_sv, i_kv, i_cn, i_dr, i_chr;
   int i_ci, i_cp, i_si, i_kval;

   // Reference model: purchase phase 0=waiting,1=paying,2=vending,3=refunding.
   int m_phase, m_credit, m_item, m_price, m_change, m_quiet;
   int m_prices[NI];

   task automatic cmp(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_step();
      exp_t e;
      bit rej = 0;
      if (!i_rn) begin
         m_phase = 0; m_credit = 0; m_item = 0; m_price = 0; m_change = 0; m_quiet = 0;
         for (int k = 0; k < NI; k++) m_prices[k] = 0;
      end else begin
         case (m_phase)
            0: begin
               rej = i_kv;
               if (i_cm && i_cw) m_prices[i_ci] = i_cp;
               if (i_sv && !i_cm) begin
                  m_phase = 1; m_item = i_si; m_price = m_prices[i_si]; m_quiet = 0;
               end
            end
            1: begin
               int total;
               bit timed;
               total = m_credit + (i_kv ? i_kval : 0);
               timed = 0;
               if (total > MAXC) begin total = MAXC; rej = 1; end
               m_credit = total;
               if (i_kv) m_quiet = 0; else m_quiet++;
`ifdef VEND_TIMEOUT_EN
               timed = (m_quiet >= TMO);
`endif
               if (i_cn || i_cm || timed) begin
                  if (m_credit == 0) m_phase = 0;
                  else begin m_phase = 3; m_change = m_credit; end
               end else if (m_credit >= m_price) begin
                  m_phase = 2;
               end
            end
            2: begin
               rej = i_kv;
               if (i_dr) begin
                  if (m_credit > m_price) begin
                     m_change = m_credit - m_price; m_credit = m_change; m_phase = 3;
                  end else begin
                     m_credit = 0; m_phase = 0;
                  end
               end
            end
            default: begin
               rej = i_kv;
               if (i_chr) begin m_phase = 0; m_credit = 0; m_change = 0; end
            end
         endcase
      end
      e.de = (m_phase == 2); e.di = (m_phase == 2) ? m_item : 0;
      e.cv = (m_phase == 3); e.cval = m_change; e.rej = rej;
      e.cr = m_credit; e.busy = (m_phase != 0);
      return e;
   endfunction

   task automatic clear_in();
      i_rn = 1; i_cm = 0; i_cw = 0; i_sv = 0; i_kv = 0; i_cn = 0; i_dr = 0; i_chr = 0;
      i_ci = 0; i_cp = 0; i_si = 0; i_kval = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      rstn = i_rn;
      bus.cfg_mode = i_cm; bus.cfg_wr = i_cw; bus.cfg_idx = 3'(i_ci); bus.cfg_price = 8'(i_cp);
      bus.sel_valid = i_sv; bus.sel_item = 3'(i_si);
      bus.coin_valid = i_kv; bus.coin_value = 8'(i_kval);
      bus.cancel = i_cn; bus.dispense_ready = i_dr; bus.change_ready = i_chr;
      sb_q.push_back(model_step());
      $display("vec %0d: rn=%0b cm=%0b wr=%0b sel=%0b/%0d coin=%0b/%0d cn=%0b dr=%0b chr=%0b",
               vectors, i_rn, i_cm, i_cw, i_sv, i_si, i_kv, i_kval, i_cn, i_dr, i_chr);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin clear_in(); tick(); end
   endtask

   task automatic coin(input int v);
      clear_in(); i_kv = 1; i_kval = v; tick();
   endtask

   task automatic program_price(input int idx, input int p);
      clear_in(); i_cm = 1; i_cw = 1; i_ci = idx; i_cp = p; tick();
      idle(1);
   endtask

   task automatic select(input int idx);
      clear_in(); i_sv = 1; i_si = idx; tick();
   endtask

   // Monitor: every registered output set is compared against the queued expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp("dispense_enable", int'(bus.dispense_enable), int'(e.de));
            cmp("dispense_item",   int'(bus.dispense_item),   e.di);
            cmp("change_valid",    int'(bus.change_valid),    int'(e.cv));
            cmp("change_value",    int'(bus.change_value),    e.cval);
            cmp("coin_reject",     int'(bus.coin_reject),     int'(e.rej));
            cmp("credit",          int'(bus.credit),          e.cr);
            cmp("busy",            int'(bus.busy),            int'(e.busy));
         end
      end
   end

   initial begin
      bit cm_sticky;
      clear_in();
      i_rn = 0;
      bus.cfg_mode = 0; bus.cfg_wr = 0; bus.cfg_idx = 0; bus.cfg_price = 0;
      bus.sel_valid = 0; bus.sel_item = 0; bus.coin_valid = 0; bus.coin_value = 0;
      bus.cancel = 0; bus.dispense_ready = 0; bus.change_ready = 0;
      tick(); tick();
      idle(2);

      // Priced purchase with change.
      program_price(3, 50);
      select(3);
      coin(20); coin(20); coin(20);
      settle();
      cmp("d22_dispense_enable", int'(bus.dispense_enable), 1);
      cmp("d22_dispense_item", int'(bus.dispense_item), 3);
      clear_in(); i_dr = 1; tick();
      settle();
      cmp("d22_change_value", int'(bus.change_value), 10);
      clear_in(); i_chr = 1; tick();

      // Free item, then exact payment.
      select(0);
      idle(1);
      settle();
      cmp("d23_free_dispense", int'(bus.dispense_enable), 1);
      clear_in(); i_dr = 1; tick();
      program_price(4, 30);
      select(4);
      coin(30);
      clear_in(); i_dr = 1; tick();
      settle();
      cmp("d23_exact_no_change", int'(bus.change_valid), 0);
      cmp("d23_exact_idle", int'(bus.busy), 0);

      // Cancel with a same-cycle coin.
      program_price(5, 100);
      select(5);
      coin(20);
      clear_in(); i_kv = 1; i_kval = 30; i_cn = 1; tick();
      settle();
      cmp("d24_change_value", int'(bus.change_value), 50);
      cmp("d24_no_dispense", int'(bus.dispense_enable), 0);
      clear_in(); i_chr = 1; tick();

      // Saturation, then coin while idle.
      program_price(6, 255);
      select(6);
      coin(250);
      coin(10);
      settle();
      cmp("d25_credit_sat", int'(bus.credit), 255);
      cmp("d25_sat_reject", int'(bus.coin_reject), 1);
      clear_in(); i_dr = 1; tick();
      coin(40);
      settle();
      cmp("d25_idle_reject", int'(bus.coin_reject), 1);
      cmp("d25_idle_credit", int'(bus.credit), 0);

      // Payment left idle for the timeout window.
      program_price(2, 200);
      select(2);
      coin(5);
      idle(TMO);
      settle();
`ifdef VEND_TIMEOUT_EN
      cmp("d26_timeout_refund", int'(bus.change_valid), 1);
      cmp("d26_timeout_value", int'(bus.change_value), 5);
`else
      cmp("d26_still_collect", int'(bus.busy), 1);
      cmp("d26_no_refund", int'(bus.change_valid), 0);
`endif
      clear_in(); i_cn = 1; tick();
      clear_in(); i_chr = 1; tick();

      // Write outside cfg_mode ignored, then reset mid-dispense.
      clear_in(); i_cw = 1; i_ci = 3; i_cp = 99; tick();
      select(3);
      coin(20); coin(20); coin(20);
      settle();
      cmp("d27_price_kept", int'(bus.dispense_enable), 1);
      clear_in(); i_rn = 0; tick();
      #1;
      cmp("d27_rst_dispense", int'(bus.dispense_enable), 0);
      cmp("d27_rst_busy", int'(bus.busy), 0);
      cmp("d27_rst_credit", int'(bus.credit), 0);
      cmp("d27_rst_item", int'(bus.dispense_item), 0);
      idle(2);

      // Randomized traffic.
      cm_sticky = 0;
      for (int n = 0; n < 4000; n++) begin
         clear_in();
         if ($urandom_range(0, 39) == 0) cm_sticky = !cm_sticky;
         i_rn  = ($urandom_range(0, 599) != 0);
         i_cm  = cm_sticky;
         i_cw  = ($urandom_range(0, 2) == 0);
         i_ci  = $urandom_range(0, NI - 1);
         i_cp  = $urandom_range(0, 120);
         i_sv  = ($urandom_range(0, 3) == 0);
         i_si  = $urandom_range(0, NI - 1);
         i_kv  = ($urandom_range(0, 2) == 0);
         i_kval = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 60);
         i_cn  = ($urandom_range(0, 24) == 0);
         i_dr  = ($urandom_range(0, 2) == 0);
         i_chr = ($urandom_range(0, 2) == 0);
         tick();
      end
      idle(3);
      settle();
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
